// File: rtl/health_controller.sv
// health_controller: owns player and boss hit-points, invulnerability and
// boss-hit pacing counters, and the game-over / win flags for the game FSM.
module health_controller #(
  parameter int PLAYER_MAX      = 3,
  parameter int BOSS_MAX        = 6,
  parameter int INVULN_CYCLES   = 50_000_000,
  parameter int BOSS_GAP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       player_hit,
  input  logic       boss_hit,
  input  logic       boss_trigger,
  output logic [1:0] health,
  output logic [2:0] boss_health,
  output logic       boss,
  output logic       invuln,
  output logic       hurt,
  output logic       game_over,
  output logic       win
);

  localparam int IW = (INVULN_CYCLES < 2) ? 1 : $clog2(INVULN_CYCLES + 1);
  localparam int GW = (BOSS_GAP_CYCLES < 2) ? 1 : $clog2(BOSS_GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_BOSS = 3'd2,
    S_DEAD = 3'd3,
    S_WON  = 3'd4
  } state_t;

  state_t          r_state;
  logic [1:0]      r_health;
  logic [2:0]      r_boss_health;
  logic            r_boss;
  logic            r_hurt;
  logic            r_game_over;
  logic            r_win;
  logic [IW-1:0]   r_inv_cnt;
  logic [GW-1:0]   r_gap_cnt;

  logic            r_start_q;
  logic            r_phit_q;
  logic            r_bhit_q;
  logic            r_btrig_q;

  logic            w_start_ev;
  logic            w_phit_ev;
  logic            w_bhit_ev;
  logic            w_btrig_ev;
  logic            w_in_game;
  logic            w_p_acc;
  logic            w_p_lethal;
  logic            w_b_acc;
  logic            w_b_lethal;

  // Saturating decrements: hit-points and counters stop at zero, never wrap.
  function automatic logic [1:0] dec_health(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

  function automatic logic [2:0] dec_boss(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic [IW-1:0] dec_inv(input logic [IW-1:0] v);
    return (v == '0) ? '0 : v - IW'(1);
  endfunction

  function automatic logic [GW-1:0] dec_gap(input logic [GW-1:0] v);
    return (v == '0) ? '0 : v - GW'(1);
  endfunction

  // Rising-edge events: a held level produces a single event.
  assign w_start_ev = start        & ~r_start_q;
  assign w_phit_ev  = player_hit   & ~r_phit_q;
  assign w_bhit_ev  = boss_hit     & ~r_bhit_q;
  assign w_btrig_ev = boss_trigger & ~r_btrig_q;

  // A hit is accepted only in a live state, outside its blocking window,
  // and only while there are hit-points left to take away.
  assign w_in_game  = (r_state == S_PLAY) || (r_state == S_BOSS);
  assign w_p_acc    = w_in_game && w_phit_ev && (r_inv_cnt == '0) && (r_health != 2'd0);
  assign w_p_lethal = w_p_acc && (r_health == 2'd1);
  assign w_b_acc    = (r_state == S_BOSS) && w_bhit_ev && (r_gap_cnt == '0) &&
                      (r_boss_health != 3'd0);
  assign w_b_lethal = w_b_acc && (r_boss_health == 3'd1);

  assign health      = r_health;
  assign boss_health = r_boss_health;
  assign boss        = r_boss;
  assign invuln      = (r_inv_cnt != '0);
  assign hurt        = r_hurt;
  assign game_over   = r_game_over;
  assign win         = r_win;

  // Previous-value registers for the edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_phit_q  <= 1'b0;
      r_bhit_q  <= 1'b0;
      r_btrig_q <= 1'b0;
    end else begin
      r_start_q <= start;
      r_phit_q  <= player_hit;
      r_bhit_q  <= boss_hit;
      r_btrig_q <= boss_trigger;
    end
  end

  // Game FSM with registered hit-points, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_health      <= 2'd0;
      r_boss_health <= 3'd0;
      r_boss        <= 1'b0;
      r_hurt        <= 1'b0;
      r_game_over   <= 1'b0;
      r_win         <= 1'b0;
      r_inv_cnt     <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_hurt    <= 1'b0;
      r_inv_cnt <= dec_inv(r_inv_cnt);
      r_gap_cnt <= dec_gap(r_gap_cnt);
      if (w_start_ev) begin
        // Restart from any state wins over every same-cycle hit.
        r_state       <= S_PLAY;
        r_health      <= 2'(PLAYER_MAX);
        r_boss_health <= 3'd0;
        r_boss        <= 1'b0;
        r_game_over   <= 1'b0;
        r_win         <= 1'b0;
        r_inv_cnt     <= '0;
        r_gap_cnt     <= '0;
      end else begin
        case (r_state)
          S_PLAY, S_BOSS: begin
            if (w_p_acc) begin
              r_health  <= dec_health(r_health);
              r_hurt    <= 1'b1;
              r_inv_cnt <= IW'(INVULN_CYCLES);
            end
            if (w_b_acc) begin
              r_boss_health <= dec_boss(r_boss_health);
              r_gap_cnt     <= GW'(BOSS_GAP_CYCLES);
            end
            if (w_p_lethal) begin
              // Player death outranks a simultaneous boss kill.
              r_state     <= S_DEAD;
              r_game_over <= 1'b1;
              r_inv_cnt   <= '0;
              r_gap_cnt   <= '0;
            end else if (w_b_lethal) begin
              r_state <= S_WON;
              r_win   <= 1'b1;
            end else if ((r_state == S_PLAY) && w_btrig_ev) begin
              r_state       <= S_BOSS;
              r_boss_health <= 3'(BOSS_MAX);
              r_boss        <= 1'b1;
            end
          end
          S_DEAD: begin
            r_inv_cnt <= '0;
            r_gap_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_health_controller.sv
// Testbench for health_controller: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural game model.
module tb_health_controller;

  localparam int PM = 3;
  localparam int BM = 6;
  localparam int IC = 4;
  localparam int BG = 2;

  logic       clk;
  logic       rst_n;
  logic       st, ph, bh, bt;
  logic [1:0] health;
  logic [2:0] boss_health;
  logic       boss, invuln, hurt, game_over, win;

  int checks;
  int errors;

  // Behavioural model of the game rules.
  typedef enum int {M_IDLE, M_PLAY, M_BOSS, M_DEAD, M_WON} mode_t;
  mode_t m_mode;
  int    m_hp, m_bhp, m_inv, m_gap;
  bit    m_boss, m_hurt, m_go, m_win;
  bit    p_st, p_ph, p_bh, p_bt;

  health_controller #(
    .PLAYER_MAX(PM), .BOSS_MAX(BM), .INVULN_CYCLES(IC), .BOSS_GAP_CYCLES(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(st), .player_hit(ph), .boss_hit(bh),
    .boss_trigger(bt), .health(health), .boss_health(boss_health), .boss(boss),
    .invuln(invuln), .hurt(hurt), .game_over(game_over), .win(win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_hp = 0; m_bhp = 0; m_inv = 0; m_gap = 0;
    m_boss = 0; m_hurt = 0; m_go = 0; m_win = 0;
    p_st = 0; p_ph = 0; p_bh = 0; p_bt = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit b, input bit t);
    bit e_st, e_ph, e_bh, e_bt, live, take_p, take_b;
    e_st = s && !p_st; e_ph = p && !p_ph; e_bh = b && !p_bh; e_bt = t && !p_bt;
    p_st = s; p_ph = p; p_bh = b; p_bt = t;
    live   = (m_mode == M_PLAY) || (m_mode == M_BOSS);
    take_p = live && e_ph && (m_inv == 0) && (m_hp > 0);
    take_b = (m_mode == M_BOSS) && e_bh && (m_gap == 0) && (m_bhp > 0);
    if (m_inv > 0) m_inv--;
    if (m_gap > 0) m_gap--;
    m_hurt = 0;
    if (e_st) begin
      m_mode = M_PLAY; m_hp = PM; m_bhp = 0; m_boss = 0;
      m_inv = 0; m_gap = 0; m_go = 0; m_win = 0;
    end else if (live) begin
      if (take_p) begin m_hp--; m_hurt = 1; m_inv = IC; end
      if (take_b) begin m_bhp--; m_gap = BG; end
      if (take_p && m_hp == 0) begin
        m_mode = M_DEAD; m_go = 1; m_inv = 0; m_gap = 0;
      end else if (take_b && m_bhp == 0) begin
        m_mode = M_WON; m_win = 1;
      end else if (m_mode == M_PLAY && e_bt) begin
        m_mode = M_BOSS; m_bhp = BM; m_boss = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".health"},      int'(health),      m_hp);
    chk({tag, ".boss_health"}, int'(boss_health), m_bhp);
    chk({tag, ".boss"},        int'(boss),        int'(m_boss));
    chk({tag, ".invuln"},      int'(invuln),      int'(m_inv != 0));
    chk({tag, ".hurt"},        int'(hurt),        int'(m_hurt));
    chk({tag, ".game_over"},   int'(game_over),   int'(m_go));
    chk({tag, ".win"},         int'(win),         int'(m_win));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(st, ph, bh, bt);
    #1;
    cmp_all(tag);
  endtask

  task automatic pulse_ph(input string tag);
    ph = 1; tick(tag); ph = 0; tick(tag);
  endtask

  task automatic pulse_bh(input string tag);
    bh = 1; tick(tag); bh = 0; tick(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int hcount, icount;
    checks = 0; errors = 0;
    st = 0; ph = 0; bh = 0; bt = 0;
    rst_n = 0;
    model_reset();

    // Reset state
    #12;
    chk("reset.health", int'(health), 0);
    chk("reset.boss_health", int'(boss_health), 0);
    chk("reset.flags", int'({boss, invuln, hurt, game_over, win}), 0);
    #1 rst_n = 1;
    tick("idle");

    // 1: start
    st = 1; tick("start");
    st = 0;
    chk("start.health", int'(health), 3);
    chk("start.boss", int'(boss), 0);
    chk("start.invuln", int'(invuln), 0);
    tick("play");

    // 2: held player_hit gives one hit and a 4-cycle invulnerability window
    hcount = 0; icount = 0;
    ph = 1;
    for (int i = 0; i < 10; i++) begin
      tick("hold");
      if (hurt) hcount++;
      if (invuln) icount++;
    end
    ph = 0;
    chk("hold.hurt_pulses", hcount, 1);
    chk("hold.invuln_cycles", icount, 4);
    chk("hold.health", int'(health), 2);
    tick("rel");
    pulse_ph("hit2");
    chk("hit2.health", int'(health), 1);
    pulse_ph("hit_blocked");
    chk("blocked.health", int'(health), 1);
    idle(5, "wait");

    // 3: boss fight to a win
    bt = 1; tick("trig");
    bt = 0;
    chk("trig.boss", int'(boss), 1);
    chk("trig.boss_health", int'(boss_health), 6);
    for (int i = 0; i < 6; i++) begin
      bh = 1; tick("bhit");
      chk("bhit.boss_health", int'(boss_health), 5 - i);
      bh = 0; tick("bgap"); tick("bgap");
    end
    chk("won.win", int'(win), 1);
    chk("won.boss", int'(boss), 1);
    pulse_ph("won_ph"); pulse_bh("won_bh");
    chk("won.health_hold", int'(health), 1);

    // 4: simultaneous lethal hits
    st = 1; tick("restart"); st = 0;
    pulse_ph("dmg"); idle(4, "w"); pulse_ph("dmg"); idle(4, "w");
    bt = 1; tick("trig2"); bt = 0;
    for (int i = 0; i < 5; i++) begin pulse_bh("bdmg"); tick("bdmg"); end
    chk("pre.health", int'(health), 1);
    chk("pre.boss_health", int'(boss_health), 1);
    ph = 1; bh = 1; tick("lethal"); ph = 0; bh = 0;
    chk("lethal.game_over", int'(game_over), 1);
    chk("lethal.win", int'(win), 0);
    chk("lethal.health", int'(health), 0);
    chk("lethal.boss_health", int'(boss_health), 0);

    // 6a: hits in DEAD do nothing
    for (int i = 0; i < 3; i++) begin pulse_ph("dead_ph"); pulse_bh("dead_bh"); end
    chk("dead.health", int'(health), 0);

    // 5: restart from DEAD, then async reset mid-invulnerability
    st = 1; tick("revive"); st = 0;
    chk("revive.health", int'(health), 3);
    chk("revive.boss", int'(boss), 0);
    chk("revive.game_over", int'(game_over), 0);
    ph = 1; tick("inv_hit"); tick("inv_hit");
    chk("inv.invuln", int'(invuln), 1);
    #1 rst_n = 0;
    #1;
    chk("areset.health", int'(health), 0);
    chk("areset.flags", int'({boss, invuln, hurt, game_over, win}), 0);
    model_reset();
    ph = 0;
    #3 rst_n = 1;
    idle(2, "post_reset");

    // 6b: boss hits in PLAY never touch boss_health
    st = 1; tick("s3"); st = 0;
    for (int i = 0; i < 4; i++) pulse_bh("play_bh");
    chk("play_bh.boss_health", int'(boss_health), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 63) == 0);
      ph = ($urandom_range(0, 2) == 0);
      bh = ($urandom_range(0, 2) == 0);
      bt = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/health_controller.md
Name: health_controller

Overview:
Sequential owner of player and boss hit-points for the game datapath.
- Converts raw hit/trigger inputs into registered `health[1:0]`, `boss_health[2:0]` and `boss`, the exact encodings consumed by the LED health decoder.
- Applies invulnerability windows, saturation and boss-fight sequencing.
- Raises game-over and win flags for the top-level game FSM.

Parameters:
- PLAYER_MAX, 3: player hit-points loaded on start; range 1..3.
- BOSS_MAX, 6: boss hit-points loaded on boss entry; range 1..6 (decoder shows codes 1..6 only).
- INVULN_CYCLES, 50_000_000: clock cycles the player ignores hits after taking damage; must be ≥1.
- BOSS_GAP_CYCLES, 25_000_000: minimum clock cycles between accepted boss hits; must be ≥1.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: start/restart request; level, synchronous to clk.
- player_hit, input, 1: player-damage request; level, synchronous.
- boss_hit, input, 1: boss-damage request; level, synchronous.
- boss_trigger, input, 1: enter boss fight; level, synchronous.
- health, output, 2: player hit-points 0..3, registered.
- boss_health, output, 3: boss hit-points 0..6, registered; never 7.
- boss, output, 1: 1 while the boss fight is active or won; registered.
- invuln, output, 1: 1 while the player invulnerability counter is non-zero.
- hurt, output, 1: one-cycle pulse on each accepted player hit.
- game_over, output, 1: 1 in state DEAD.
- win, output, 1: 1 in state WON.

Behaviour:
- Reset (`rst_n`=0, asynchronous): state IDLE; all outputs 0; both counters 0; all edge-detect registers 0.
- Edge detection: one register of previous value per input (`start`, `player_hit`, `boss_hit`, `boss_trigger`). An event is `in & ~prev`. Level-held inputs produce exactly one event.
- States: IDLE, PLAY, BOSS, DEAD, WON (3-bit encoding, implementer's choice).
- IDLE:
  - All outputs 0.
  - start event -> PLAY; `health`=PLAYER_MAX on the same edge.
- PLAY:
  - player_hit event with `invuln`=0 and `health`>0: `health`-1; `hurt`=1 for one cycle; invuln counter loads INVULN_CYCLES.
  - boss_trigger event -> BOSS; `boss_health`=BOSS_MAX; `boss`=1.
  - boss_hit is ignored.
- BOSS:
  - Player-hit rules are identical to PLAY.
  - boss_hit event with boss gap counter=0 and `boss_health`>0: `boss_health`-1; gap counter loads BOSS_GAP_CYCLES.
  - boss_trigger is ignored.
- Counters:
  - Each counter decrements by 1 per cycle while non-zero and saturates at 0.
  - `invuln` is the registered flag (counter≠0). It goes high the cycle after the accepted hit and stays high exactly INVULN_CYCLES cycles.
  - A hit arriving on the cycle the counter becomes 0 (`invuln`=0) is accepted.
- Lethal transitions, evaluated on the same edge as the decrement:
  - `health` reaching 0 -> DEAD.
  - `boss_health` reaching 0 -> WON.
  - Simultaneous lethal player hit and lethal boss hit -> DEAD (player death has priority); `boss_health` still decrements.
- Simultaneous non-lethal player hit and boss hit in BOSS: both are applied on the same edge.
- Saturation: decrements never wrap; `health` never below 0; `boss_health` never below 0 and never above BOSS_MAX.
- DEAD:
  - `game_over`=1; `health`=0; `boss`/`boss_health` hold their values; all hits ignored; counters cleared.
  - start event -> PLAY with `health`=PLAYER_MAX, `boss`=0, `boss_health`=0, `game_over`=0.
- WON:
  - `win`=1; `boss`=1; `boss_health`=0; `health` holds; hits ignored.
  - start event -> PLAY, with the same reload as from DEAD.
- start event in PLAY or BOSS: full restart. Go to PLAY with `health`=PLAYER_MAX, boss cleared, counters cleared. A restart overrides any same-cycle hit.
- Reset asserted mid-game, including mid-invulnerability: immediate return to the reset values; no pending events survive.
- Latency: one clock from input rising edge to updated outputs. No combinational input-to-output paths.

Test Plan:
1. Reset, then a start pulse -> `health`=3, `boss`=0, `boss_health`=0, `invuln`=0 one cycle after the start edge.
2. Run with INVULN_CYCLES=4. In PLAY, `player_hit` held high 10 cycles -> exactly one decrement (`health` 3->2), one `hurt` pulse, `invuln` high for 4 cycles. A second hit edge on cycle 3 is ignored; one on cycle 6 makes `health`=1.
3. boss_trigger edge -> `boss`=1, `boss_health`=6. Run with BOSS_GAP_CYCLES=2 and six boss_hit edges spaced 3 cycles apart -> `boss_health` 6,5,4,3,2,1,0. Then state WON, `win`=1, `boss`=1; further hits leave all outputs unchanged.
4. `health`=1 and `boss_health`=1, with lethal player_hit and boss_hit edges on the same cycle -> `game_over`=1, `win`=0, `health`=0, `boss_health`=0.
5. In DEAD, start edge -> `health`=3, `boss`=0, `boss_health`=0, `game_over`=0. Then assert `rst_n`=0 mid-invulnerability -> all outputs 0 asynchronously, state IDLE after release.
6. Repeated player hits at `health`=0 (DEAD) and boss hits in PLAY -> no underflow, `boss_health` stays 0, `hurt` never pulses.
